// File: rtl/seg_uop_responder.sv
// Segment micro-op responder: forwards micro-ops to the VLSU, tracks them in an in-order tag FIFO, returns one response each.
// Latency: one registered response per completion, one cycle after the completion pulse.
// Backpressure: ready follows VLSU ready, gated off while the tag FIFO is full or while draining after a fault.
module seg_uop_responder #(
    parameter int unsigned VstartWidth = 16,
    parameter int unsigned NfWidth     = 3,
    parameter int unsigned TvalWidth   = 64,
    parameter int unsigned Depth       = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   uop_valid_i,
    output logic                   uop_ready_o,
    input  logic [VstartWidth-1:0] uop_vstart_i,
    input  logic [NfWidth-1:0]     uop_field_i,
    input  logic                   uop_last_i,
    output logic                   be_req_valid_o,
    input  logic                   be_req_ready_i,
    input  logic                   be_done_valid_i,
    input  logic                   be_done_exc_i,
    input  logic [TvalWidth-1:0]   be_done_tval_i,
    output logic                   resp_valid_o,
    output logic                   resp_exc_o,
    output logic [VstartWidth-1:0] resp_vstart_o,
    output logic [NfWidth-1:0]     resp_field_o,
    output logic [TvalWidth-1:0]   resp_tval_o,
    output logic                   resp_last_o,
    output logic                   idle_o,
    output logic                   proto_err_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned PtrW  = AddrW + 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    typedef struct packed {
        logic [VstartWidth-1:0] vstart;
        logic [NfWidth-1:0]     field;
        logic                   last;
    } tag_t;

    tag_t            r_mem [Depth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    state_e          r_state;
    state_e          w_next_state;

    logic [PtrW-1:0] w_occ;
    logic            w_empty;
    logic            w_full;
    logic            w_accept_en;
    logic            w_push;
    logic            w_pop;
    logic            w_run;
    tag_t            w_head;

    logic                   r_resp_valid;
    logic                   r_resp_exc;
    logic [VstartWidth-1:0] r_resp_vstart;
    logic [NfWidth-1:0]     r_resp_field;
    logic [TvalWidth-1:0]   r_resp_tval;
    logic                   r_resp_last;
    logic                   r_proto_err;

    assign w_occ   = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_occ == '0);
    assign w_full  = (r_wr_ptr[PtrW-1] != r_rd_ptr[PtrW-1]) &&
                     (r_wr_ptr[AddrW-1:0] == r_rd_ptr[AddrW-1:0]);
    assign w_run   = (r_state == ST_RUN);

    // Full is the registered value: a same-cycle pop does not open a slot until next cycle.
    assign w_accept_en    = w_run && !w_full;
    assign be_req_valid_o = uop_valid_i && w_accept_en;
    assign uop_ready_o    = be_req_ready_i && w_accept_en;

    assign w_push = uop_valid_i && uop_ready_o;
    assign w_pop  = be_done_valid_i && !w_empty;
    assign w_head = r_mem[r_rd_ptr[AddrW-1:0]];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AddrW-1:0]] <= tag_t'{vstart: uop_vstart_i, field: uop_field_i, last: uop_last_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_state  <= ST_RUN;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN:   if (w_pop && be_done_exc_i) w_next_state = ST_DRAIN;
            // Leaves on registered emptiness, so a drain ending in a pop spends one more cycle here.
            ST_DRAIN: if (w_empty) w_next_state = ST_RUN;
            default:  w_next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resp_valid  <= 1'b0;
            r_resp_exc    <= 1'b0;
            r_resp_vstart <= '0;
            r_resp_field  <= '0;
            r_resp_tval   <= '0;
            r_resp_last   <= 1'b0;
            r_proto_err   <= 1'b0;
        end else begin
            r_resp_valid <= w_pop && w_run;
            if (w_pop && w_run) begin
                r_resp_exc    <= be_done_exc_i;
                r_resp_vstart <= w_head.vstart;
                r_resp_field  <= w_head.field;
                r_resp_tval   <= be_done_exc_i ? be_done_tval_i : '0;
                r_resp_last   <= w_head.last;
            end
            if (be_done_valid_i && w_empty) r_proto_err <= 1'b1;
        end
    end

    assign resp_valid_o  = r_resp_valid;
    assign resp_exc_o    = r_resp_exc;
    assign resp_vstart_o = r_resp_vstart;
    assign resp_field_o  = r_resp_field;
    assign resp_tval_o   = r_resp_tval;
    assign resp_last_o   = r_resp_last;
    assign proto_err_o   = r_proto_err;
    assign idle_o        = w_empty && w_run;

endmodule

// File: tb/tb_seg_uop_responder.sv
// Scoreboard bench for seg_uop_responder: queue-based reference model, directed scenarios plus random traffic.
module tb_seg_uop_responder;
    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        uop_valid_i = 1'b0;
    logic        uop_ready_o;
    logic [15:0] uop_vstart_i = '0;
    logic [2:0]  uop_field_i = '0;
    logic        uop_last_i = 1'b0;
    logic        be_req_valid_o;
    logic        be_req_ready_i = 1'b0;
    logic        be_done_valid_i = 1'b0;
    logic        be_done_exc_i = 1'b0;
    logic [63:0] be_done_tval_i = '0;
    logic        resp_valid_o;
    logic        resp_exc_o;
    logic [15:0] resp_vstart_o;
    logic [2:0]  resp_field_o;
    logic [63:0] resp_tval_o;
    logic        resp_last_o;
    logic        idle_o;
    logic        proto_err_o;

    seg_uop_responder #(
        .VstartWidth(16), .NfWidth(3), .TvalWidth(64), .Depth(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .uop_valid_i(uop_valid_i), .uop_ready_o(uop_ready_o),
        .uop_vstart_i(uop_vstart_i), .uop_field_i(uop_field_i), .uop_last_i(uop_last_i),
        .be_req_valid_o(be_req_valid_o), .be_req_ready_i(be_req_ready_i),
        .be_done_valid_i(be_done_valid_i), .be_done_exc_i(be_done_exc_i), .be_done_tval_i(be_done_tval_i),
        .resp_valid_o(resp_valid_o), .resp_exc_o(resp_exc_o), .resp_vstart_o(resp_vstart_o),
        .resp_field_o(resp_field_o), .resp_tval_o(resp_tval_o), .resp_last_o(resp_last_o),
        .idle_o(idle_o), .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] vs;
        logic [2:0]  fld;
        logic        last;
    } uop_t;

    typedef struct {
        logic        exc;
        logic [15:0] vs;
        logic [2:0]  fld;
        logic [63:0] tval;
        logic        last;
    } rsp_t;

    uop_t m_q[$];
    rsp_t exp_q[$];
    bit   m_drain = 1'b0;
    bit   m_proto = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Monitor: every expected response must appear exactly one negedge after it was predicted.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            if (exp_q.size() > 0) begin
                rsp_t r;
                r = exp_q.pop_front();
                chk("resp_valid", resp_valid_o, 1);
                if (resp_valid_o === 1'b1) begin
                    chk("resp_exc", resp_exc_o, r.exc);
                    chk("resp_vstart", resp_vstart_o, r.vs);
                    chk("resp_field", resp_field_o, r.fld);
                    chk("resp_tval", resp_tval_o, r.tval);
                    chk("resp_last", resp_last_o, r.last);
                end
            end else if (resp_valid_o !== 1'b0) begin
                chk("resp_unexpected", resp_valid_o, 0);
            end
        end
    end

    task automatic cyc(input bit v, input logic [15:0] vs, input logic [2:0] f, input bit l,
                       input bit rdy, input bit dn, input bit ex, input logic [63:0] tv);
        int   sz;
        bit   acc;
        bit   nd;
        uop_t u;
        rsp_t r;
        @(negedge clk_i);
        uop_valid_i = v; uop_vstart_i = vs; uop_field_i = f; uop_last_i = l;
        be_req_ready_i = rdy; be_done_valid_i = dn; be_done_exc_i = ex; be_done_tval_i = tv;
        #1;
        sz  = m_q.size();
        acc = !m_drain && (sz < DEPTH);
        chk("uop_ready", uop_ready_o, rdy && acc);
        chk("be_req_valid", be_req_valid_o, v && acc);
        chk("idle", idle_o, (sz == 0) && !m_drain);
        chk("proto_err", proto_err_o, m_proto);
        @(posedge clk_i);
        nd = m_drain;
        if (dn && sz > 0) begin
            u = m_q.pop_front();
            if (!m_drain) begin
                r.exc = ex; r.vs = u.vs; r.fld = u.fld; r.last = u.last;
                r.tval = ex ? tv : 64'h0;
                exp_q.push_back(r);
                if (ex) nd = 1'b1;
            end
        end else if (dn) begin
            m_proto = 1'b1;
        end
        if (m_drain && sz == 0) nd = 1'b0;
        if (v && rdy && acc) begin
            u.vs = vs; u.fld = f; u.last = l;
            m_q.push_back(u);
        end
        m_drain = nd;
    endtask

    task automatic idle_cyc();
        cyc(0, 16'h0, 3'h0, 0, 1, 0, 0, 64'h0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        uop_valid_i = 0; be_done_valid_i = 0; be_done_exc_i = 0;
        m_q.delete(); exp_q.delete(); m_drain = 1'b0; m_proto = 1'b0;
        be_req_ready_i = 1'b1;
        #1;
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_resp_exc", resp_exc_o, 0);
        chk("rst_resp_vstart", resp_vstart_o, 0);
        chk("rst_resp_field", resp_field_o, 0);
        chk("rst_resp_tval", resp_tval_o, 0);
        chk("rst_resp_last", resp_last_o, 0);
        chk("rst_idle", idle_o, 1);
        chk("rst_proto_err", proto_err_o, 0);
        chk("rst_be_req_valid", be_req_valid_o, 0);
        chk("rst_uop_ready_hi", uop_ready_o, 1);
        be_req_ready_i = 1'b0;
        #1;
        chk("rst_uop_ready_lo", uop_ready_o, 0);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b1;
    endtask

    task automatic flush_outstanding();
        for (int k = 0; k < 20 && m_q.size() > 0; k++) cyc(0, 16'h0, 3'h0, 0, 1, 1, 0, 64'h0);
        idle_cyc();
        idle_cyc();
    endtask

    initial begin
        do_reset();

        // Three fields, two segments; each completion two cycles after its accept.
        for (int t = 0; t < 8; t++) begin
            cyc(t < 6, 16'(t / 3), 3'(t % 3), t == 5, 1, t >= 2, 0, 64'h0);
        end
        idle_cyc();
        idle_cyc();

        // Fill to Depth with no completions, then completion plus valid uop while full.
        for (int t = 0; t < 5; t++) cyc(1, 16'h10, 3'(t), 0, 1, 0, 0, 64'h0);
        cyc(1, 16'h11, 3'h5, 0, 1, 1, 0, 64'h0);
        cyc(1, 16'h11, 3'h5, 1, 1, 0, 0, 64'h0);
        flush_outstanding();

        // Fault on the second of four outstanding micro-ops.
        for (int t = 0; t < 4; t++) cyc(1, 16'h3, 3'(t), t == 3, 1, 0, 0, 64'h0);
        cyc(0, 16'h0, 3'h0, 0, 1, 1, 0, 64'h0);
        cyc(0, 16'h0, 3'h0, 0, 1, 1, 1, 64'h8000_0040);
        cyc(0, 16'h0, 3'h0, 0, 1, 1, 1, 64'hdead);
        cyc(0, 16'h0, 3'h0, 0, 1, 1, 0, 64'h0);
        idle_cyc();
        idle_cyc();

        // Spurious completion with an empty FIFO, then more traffic with the flag sticky.
        cyc(0, 16'h0, 3'h0, 0, 1, 1, 0, 64'h0);
        for (int t = 0; t < 4; t++) cyc(1, 16'h20, 3'(t), 0, 1, t > 0, 0, 64'h0);
        flush_outstanding();

        for (int t = 0; t < 2000; t++) begin
            cyc($urandom % 2 == 0, 16'($urandom), 3'($urandom), $urandom % 4 == 0,
                $urandom % 4 != 0, $urandom % 3 == 0, $urandom % 12 == 0,
                {$urandom, $urandom});
        end
        flush_outstanding();

        // Reset while draining with two micro-ops still outstanding.
        do_reset();
        for (int t = 0; t < 3; t++) cyc(1, 16'h7, 3'(t), 0, 1, 0, 0, 64'h0);
        cyc(0, 16'h0, 3'h0, 0, 1, 1, 1, 64'h1234);
        chk("drain_entered", m_drain, 1);
        do_reset();
        idle_cyc();
        cyc(0, 16'h0, 3'h0, 0, 1, 1, 0, 64'h0);
        idle_cyc();
        idle_cyc();

        chk("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
